// File: rtl/data_mem_ctrl_if.sv
// MEM-stage side of the byte-serial data-memory controller: word request in,
// assembled load word and pipeline stall request out.
interface data_mem_ctrl_if;
  logic        req_ce_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [3:0]  req_sel_i;
  logic [31:0] req_data_i;
  logic        mem_stall_i;
  logic [31:0] rdata_o;
  logic        stall_req_o;

  modport master (
    output req_ce_i, req_we_i, req_addr_i, req_sel_i, req_data_i, mem_stall_i,
    input  rdata_o, stall_req_o
  );

  modport slave (
    input  req_ce_i, req_we_i, req_addr_i, req_sel_i, req_data_i, mem_stall_i,
    output rdata_o, stall_req_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-serial data-memory controller: turns one MEM-stage word request into one
// 8-bit synchronous-RAM access per selected lane, stalling the pipeline meanwhile.
module data_mem_ctrl #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_din_o,
  input  logic [7:0]        ram_dout_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_TAIL   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [1:0]  lane_r, lane_s;
  logic [3:0]  mask_r, mask_s;
  logic [3:0]  mask_rem_s;
  logic [31:0] rdata_r, rdata_s;
  logic [1:0]  cap_lane_r, cap_lane_s;
  logic        cap_vld_r, cap_vld_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic        ram_we_s;
  logic [7:0]  ram_din_s;
  logic        addr_unused_s;

  // Mask bit k stands for lane k, i.e. sel bit 3-k.
  function automatic logic [3:0] lane_mask(input logic [3:0] sel);
    return {sel[0], sel[1], sel[2], sel[3]};
  endfunction

  function automatic logic [1:0] first_lane(input logic [3:0] m);
    logic [1:0] l;
    if (m[0])      l = 2'd0;
    else if (m[1]) l = 2'd1;
    else if (m[2]) l = 2'd2;
    else           l = 2'd3;
    return l;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      2'd3:    r[7:0]   = b;
      default: r = w;
    endcase
    return r;
  endfunction

  // Next-state, datapath update and RAM drive for the current state.
  always_comb begin
    state_s    = state_r;
    lane_s     = lane_r;
    mask_s     = mask_r;
    mask_rem_s = 4'b0000;
    rdata_s    = rdata_r;
    cap_lane_s = cap_lane_r;
    cap_vld_s  = cap_vld_r;
    ram_addr_s = {ADDR_W{1'b0}};
    ram_we_s   = 1'b0;
    ram_din_s  = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_ce_i) begin
          mask_s    = lane_mask(bus.req_sel_i);
          rdata_s   = 32'h0000_0000;
          cap_vld_s = 1'b0;
          if (bus.req_sel_i != 4'b0000) begin
            state_s = ST_ACCESS;
            lane_s  = first_lane(lane_mask(bus.req_sel_i));
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!bus.req_ce_i) begin
          state_s = ST_IDLE;
        end else begin
          ram_addr_s = {bus.req_addr_i[ADDR_W-1:2], lane_r};
          // Sync RAM: the byte arriving now belongs to the lane issued last cycle.
          if (bus.req_we_i) begin
            ram_we_s  = 1'b1;
            ram_din_s = get_byte(bus.req_data_i, lane_r);
          end else begin
            if (cap_vld_r) begin
              rdata_s = put_byte(rdata_r, cap_lane_r, ram_dout_i);
            end else begin
              rdata_s = rdata_r;
            end
            cap_lane_s = lane_r;
            cap_vld_s  = 1'b1;
          end
          mask_rem_s = mask_r & ~(4'b0001 << lane_r);
          mask_s     = mask_rem_s;
          if (mask_rem_s == 4'b0000) begin
            state_s = bus.req_we_i ? ST_DONE : ST_TAIL;
          end else begin
            lane_s = first_lane(mask_rem_s);
          end
        end
      end
      ST_TAIL: begin
        if (!bus.req_ce_i) begin
          state_s = ST_IDLE;
        end else begin
          rdata_s   = put_byte(rdata_r, cap_lane_r, ram_dout_i);
          cap_vld_s = 1'b0;
          state_s   = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.mem_stall_i) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      lane_r     <= 2'd0;
      mask_r     <= 4'b0000;
      rdata_r    <= 32'h0000_0000;
      cap_lane_r <= 2'd0;
      cap_vld_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      lane_r     <= lane_s;
      mask_r     <= mask_s;
      rdata_r    <= rdata_s;
      cap_lane_r <= cap_lane_s;
      cap_vld_r  <= cap_vld_s;
    end
  end

  // Write enable is gated by reset so a reset mid-store cannot land a byte.
  assign ram_we_o        = ram_we_s & rst;
  assign ram_addr_o      = ram_addr_s;
  assign ram_din_o       = ram_din_s;
  assign bus.rdata_o     = rdata_r;
  assign bus.stall_req_o = bus.req_ce_i & (state_r != ST_DONE);
  assign addr_unused_s   = ^{bus.req_addr_i[31:ADDR_W], bus.req_addr_i[1:0]};

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural sync RAM and a queue
// scoreboard of expected values.
module tb_data_mem_ctrl;
  logic        clk;
  logic        rst;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;

  logic [7:0]  ram_mem [0:131071];
  logic        tb_we;
  logic [16:0] tb_addr;
  logic [7:0]  tb_din;
  int          wr_cnt;

  logic [63:0] exp_q [$];
  int          n_tests;
  int          n_fail;
  int          cycles;
  int          wr_base;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.ADDR_W(17)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit sync RAM plus a bench preload port and a write counter.
  always @(posedge clk) begin
    if (tb_we) begin
      ram_mem[tb_addr] <= tb_din;
    end else if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      wr_cnt <= wr_cnt + 1;
    end
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] exp_v;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_din = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Issue a request at a negedge and count stall cycles until DONE (bounded).
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] data, output int cyc);
    bus.req_ce_i   = 1'b1;
    bus.req_we_i   = we;
    bus.req_addr_i = addr;
    bus.req_sel_i  = sel;
    bus.req_data_i = data;
    #1;
    cyc = 0;
    while (bus.stall_req_o && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic release_req();
    bus.req_ce_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; wr_cnt = 0;
    tb_we = 1'b0; tb_addr = 17'd0; tb_din = 8'h00;
    rst = 1'b0;
    bus.req_ce_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = 32'h0;
    bus.req_sel_i = 4'b0000; bus.req_data_i = 32'h0; bus.mem_stall_i = 1'b0;

    poke(17'h100, 8'h11); poke(17'h101, 8'h22); poke(17'h102, 8'h33); poke(17'h103, 8'h44);
    poke(17'h200, 8'h01); poke(17'h201, 8'h02); poke(17'h202, 8'h03); poke(17'h203, 8'h04);
    poke(17'h300, 8'h00); poke(17'h301, 8'h00); poke(17'h302, 8'h00); poke(17'h303, 8'h00);
    poke(17'h400, 8'hEE); poke(17'h401, 8'hEE); poke(17'h402, 8'hEE); poke(17'h403, 8'hEE);

    @(negedge clk); #1;
    push(64'h0); check("rst_rdata", bus.rdata_o);
    push(64'h0); check("rst_we", ram_we);
    push(64'h0); check("rst_addr", ram_addr);
    push(64'h0); check("rst_stall", bus.stall_req_o);
    rst = 1'b1;
    @(negedge clk);

    // LW 0x100
    wr_base = wr_cnt;
    run_req(1'b0, 32'h0000_0100, 4'b1111, 32'h0, cycles);
    push(64'd6);           check("lw_cycles", cycles);
    push(64'h1122_3344);   check("lw_rdata", bus.rdata_o);
    push(64'd0);           check("lw_writes", wr_cnt - wr_base);
    release_req();

    // SB 0x203
    wr_base = wr_cnt;
    run_req(1'b1, 32'h0000_0203, 4'b0001, 32'hAAAA_AAAA, cycles);
    push(64'd2);   check("sb_cycles", cycles);
    release_req();
    push(64'd1);   check("sb_writes", wr_cnt - wr_base);
    push(64'hAA);  check("sb_byte", ram_mem[17'h203]);
    push(64'h03);  check("sb_neigh", ram_mem[17'h202]);

    // SH 0x300
    wr_base = wr_cnt;
    run_req(1'b1, 32'h0000_0300, 4'b1100, 32'hBEEF_BEEF, cycles);
    push(64'd3);   check("sh_cycles", cycles);
    release_req();
    push(64'd2);   check("sh_writes", wr_cnt - wr_base);
    push(64'hBE);  check("sh_b0", ram_mem[17'h300]);
    push(64'hEF);  check("sh_b1", ram_mem[17'h301]);
    push(64'h00);  check("sh_b2", ram_mem[17'h302]);

    // LBU 0x102 held in DONE by mem_stall_i
    bus.mem_stall_i = 1'b1;
    run_req(1'b0, 32'h0000_0102, 4'b0010, 32'h0, cycles);
    push(64'd3);   check("lbu_cycles", cycles);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      push(64'h0000_3300); check("lbu_hold_rdata", bus.rdata_o);
      push(64'h0);         check("lbu_hold_we", ram_we);
      push(64'h0);         check("lbu_hold_addr", ram_addr);
      push(64'h0);         check("lbu_hold_stall", bus.stall_req_o);
    end
    bus.mem_stall_i = 1'b0;
    @(negedge clk); #1;
    push(64'h1);   check("lbu_idle_stall", bus.stall_req_o);
    release_req();

    // sel == 0
    wr_base = wr_cnt;
    bus.req_ce_i = 1'b1; bus.req_we_i = 1'b0; bus.req_sel_i = 4'b0000;
    bus.req_addr_i = 32'h0000_0500; #1;
    push(64'h0);   check("sel0_addr", ram_addr);
    run_req(1'b0, 32'h0000_0500, 4'b0000, 32'h0, cycles);
    push(64'd1);   check("sel0_cycles", cycles);
    push(64'h0);   check("sel0_rdata", bus.rdata_o);
    release_req();
    push(64'd0);   check("sel0_writes", wr_cnt - wr_base);

    // Reset after two bytes of SW to 0x400
    wr_base = wr_cnt;
    bus.req_ce_i = 1'b1; bus.req_we_i = 1'b1; bus.req_addr_i = 32'h0000_0400;
    bus.req_sel_i = 4'b1111; bus.req_data_i = 32'h5A6B_7C8D;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    push(64'h0);   check("rstw_we_gate", ram_we);
    bus.req_ce_i = 1'b0;
    @(negedge clk); #1;
    push(64'h0);   check("rstw_rdata", bus.rdata_o);
    push(64'h0);   check("rstw_addr", ram_addr);
    push(64'h0);   check("rstw_din", ram_din);
    push(64'h0);   check("rstw_stall", bus.stall_req_o);
    push(64'd2);   check("rstw_writes", wr_cnt - wr_base);
    push(64'h5A);  check("rstw_b0", ram_mem[17'h400]);
    push(64'h6B);  check("rstw_b1", ram_mem[17'h401]);
    push(64'hEE);  check("rstw_b2", ram_mem[17'h402]);
    push(64'hEE);  check("rstw_b3", ram_mem[17'h403]);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
